// File: rtl/iir_biquad_mc.sv
`default_nettype none
// ============================================================================
// Module   : iir_biquad_mc
// Function : Multi-channel, time-multiplexed second-order IIR (biquad) filter
//            in signed fixed point. One shared multiplier is sequenced over
//            the five taps. Per-channel x1/x2/y1/y2 histories are kept.
// Revision : 1.0 - initial release
// ============================================================================
module iir_biquad_mc #(
    parameter int N_BITS   = 32,
    parameter int FRAC     = 16,
    parameter int N_CH     = 4,
    parameter int SATURATE = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_BITS-1:0]       x_i,
    input  logic [$clog2(N_CH)-1:0] ch_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic [N_BITS-1:0]       b0_i,
    input  logic [N_BITS-1:0]       b1_i,
    input  logic [N_BITS-1:0]       b2_i,
    input  logic [N_BITS-1:0]       a1_i,
    input  logic [N_BITS-1:0]       a2_i,
    input  logic [N_BITS-1:0]       offset_i,
    input  logic                    hist_clr_i,
    output logic [N_BITS-1:0]       y_o,
    output logic [$clog2(N_CH)-1:0] ch_o,
    output logic                    valid_o
);

    localparam int c_ch_w  = $clog2(N_CH);
    localparam int c_p_w   = 2 * N_BITS;
    localparam int c_acc_w = 2 * N_BITS + 3;

    // Largest / smallest representable N_BITS value, widened to the accumulator
    localparam logic signed [c_acc_w-1:0] c_acc_max = {{(N_BITS+4){1'b0}}, {(N_BITS-1){1'b1}}};
    localparam logic signed [c_acc_w-1:0] c_acc_min = {{(N_BITS+4){1'b1}}, {(N_BITS-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic [2:0] step_q, step_d;

    // Operands latched at acceptance so later input changes cannot disturb
    // the sample being processed
    logic [N_BITS-1:0] x_q, x_d;
    logic [c_ch_w-1:0] ch_q, ch_d;
    logic [N_BITS-1:0] b0_q, b0_d, b1_q, b1_d, b2_q, b2_d;
    logic [N_BITS-1:0] a1_q, a1_d, a2_q, a2_d;
    logic [N_BITS-1:0] off_q, off_d;
    logic [N_BITS-1:0] hx1_q, hx1_d, hx2_q, hx2_d, hy1_q, hy1_d, hy2_q, hy2_d;

    logic signed [c_acc_w-1:0] acc_q, acc_d;

    // Per-channel histories
    logic [N_BITS-1:0] x1_q [N_CH];
    logic [N_BITS-1:0] x1_d [N_CH];
    logic [N_BITS-1:0] x2_q [N_CH];
    logic [N_BITS-1:0] x2_d [N_CH];
    logic [N_BITS-1:0] y1_q [N_CH];
    logic [N_BITS-1:0] y1_d [N_CH];
    logic [N_BITS-1:0] y2_q [N_CH];
    logic [N_BITS-1:0] y2_d [N_CH];

    logic [N_BITS-1:0] y_q, y_d;
    logic [c_ch_w-1:0] cho_q, cho_d;
    logic              valid_q, valid_d;

    logic [N_BITS-1:0]         w_coef;
    logic [N_BITS-1:0]         w_data;
    logic signed [c_p_w-1:0]   w_coef_ext;
    logic signed [c_p_w-1:0]   w_data_ext;
    logic signed [c_p_w-1:0]   w_prod;
    logic signed [c_acc_w-1:0] w_prod_ext;
    logic                      w_sub;
    logic signed [c_acc_w-1:0] w_quant;
    logic [N_BITS-1:0]         w_ys;
    logic signed [c_acc_w-1:0] w_sum;
    logic [N_BITS-1:0]         w_y;

    // Clamp (or wrap) an accumulator-width value into N_BITS
    function automatic logic [N_BITS-1:0] sat_fn(input logic signed [c_acc_w-1:0] v);
        logic [N_BITS-1:0] r;
        r = v[N_BITS-1:0];
        if (SATURATE != 0) begin
            if (v > c_acc_max) begin
                r = {1'b0, {(N_BITS-1){1'b1}}};
            end else if (v < c_acc_min) begin
                r = {1'b1, {(N_BITS-1){1'b0}}};
            end
        end
        return r;
    endfunction

    // Shared multiplier operand select, product, and output quantisation
    always_comb begin
        w_coef = a2_q;
        w_data = hy2_q;
        case (step_q)
            3'd0:    begin w_coef = b0_q; w_data = x_q;   end
            3'd1:    begin w_coef = b1_q; w_data = hx1_q; end
            3'd2:    begin w_coef = b2_q; w_data = hx2_q; end
            3'd3:    begin w_coef = a1_q; w_data = hy1_q; end
            default: begin w_coef = a2_q; w_data = hy2_q; end
        endcase
        w_sub      = (step_q >= 3'd3);
        w_coef_ext = {{N_BITS{w_coef[N_BITS-1]}}, w_coef};
        w_data_ext = {{N_BITS{w_data[N_BITS-1]}}, w_data};
        w_prod     = w_coef_ext * w_data_ext;
        w_prod_ext = {{3{w_prod[c_p_w-1]}}, w_prod};
        // Arithmetic shift gives floor rounding
        w_quant    = acc_q >>> FRAC;
        w_ys       = sat_fn(w_quant);
        w_sum      = {{(N_BITS+3){w_ys[N_BITS-1]}}, w_ys}
                   + {{(N_BITS+3){off_q[N_BITS-1]}}, off_q};
        w_y        = sat_fn(w_sum);
    end

    // Sequencer: accept in IDLE, five MAC steps, then write back
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        x_d     = x_q;
        ch_d    = ch_q;
        b0_d    = b0_q;
        b1_d    = b1_q;
        b2_d    = b2_q;
        a1_d    = a1_q;
        a2_d    = a2_q;
        off_d   = off_q;
        hx1_d   = hx1_q;
        hx2_d   = hx2_q;
        hy1_d   = hy1_q;
        hy2_d   = hy2_q;
        acc_d   = acc_q;
        x1_d    = x1_q;
        x2_d    = x2_q;
        y1_d    = y1_q;
        y2_d    = y2_q;
        y_d     = y_q;
        cho_d   = cho_q;
        valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (hist_clr_i) begin
                    for (int i = 0; i < N_CH; i++) begin
                        x1_d[i] = '0;
                        x2_d[i] = '0;
                        y1_d[i] = '0;
                        y2_d[i] = '0;
                    end
                end else if (valid_i) begin
                    x_d     = x_i;
                    ch_d    = ch_i;
                    b0_d    = b0_i;
                    b1_d    = b1_i;
                    b2_d    = b2_i;
                    a1_d    = a1_i;
                    a2_d    = a2_i;
                    off_d   = offset_i;
                    hx1_d   = x1_q[ch_i];
                    hx2_d   = x2_q[ch_i];
                    hy1_d   = y1_q[ch_i];
                    hy2_d   = y2_q[ch_i];
                    acc_d   = '0;
                    step_d  = 3'd0;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                acc_d  = w_sub ? (acc_q - w_prod_ext) : (acc_q + w_prod_ext);
                step_d = step_q + 3'd1;
                if (step_q == 3'd4) begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                x2_d[ch_q] = hx1_q;
                x1_d[ch_q] = x_q;
                y2_d[ch_q] = hy1_q;
                // History keeps the pre-offset value
                y1_d[ch_q] = w_ys;
                y_d        = w_y;
                cho_d      = ch_q;
                valid_d    = 1'b1;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            x_q     <= '0;
            ch_q    <= '0;
            b0_q    <= '0;
            b1_q    <= '0;
            b2_q    <= '0;
            a1_q    <= '0;
            a2_q    <= '0;
            off_q   <= '0;
            hx1_q   <= '0;
            hx2_q   <= '0;
            hy1_q   <= '0;
            hy2_q   <= '0;
            acc_q   <= '0;
            for (int i = 0; i < N_CH; i++) begin
                x1_q[i] <= '0;
                x2_q[i] <= '0;
                y1_q[i] <= '0;
                y2_q[i] <= '0;
            end
            y_q     <= '0;
            cho_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            x_q     <= x_d;
            ch_q    <= ch_d;
            b0_q    <= b0_d;
            b1_q    <= b1_d;
            b2_q    <= b2_d;
            a1_q    <= a1_d;
            a2_q    <= a2_d;
            off_q   <= off_d;
            hx1_q   <= hx1_d;
            hx2_q   <= hx2_d;
            hy1_q   <= hy1_d;
            hy2_q   <= hy2_d;
            acc_q   <= acc_d;
            x1_q    <= x1_d;
            x2_q    <= x2_d;
            y1_q    <= y1_d;
            y2_q    <= y2_d;
            y_q     <= y_d;
            cho_q   <= cho_d;
            valid_q <= valid_d;
        end
    end

    // Ready is held low while reset is asserted so every output reads 0
    assign ready_o = (state_q == S_IDLE) && !hist_clr_i && !reset;
    assign y_o     = y_q;
    assign ch_o    = cho_q;
    assign valid_o = valid_q;

endmodule
`default_nettype wire
